// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, state type and small helpers for the round-robin mux arbiter.
// The package is named mux_arb_pkg. The files that use it import it with mux_arb_pkg::*.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Increment the hold counter, but stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Convert a requester index into its one-hot grant code.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r = {N_REQ{1'b0}};
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the mux arbiter.
// The master modport is for the requester side. The slave modport is for the arbiter.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             preempt;

  modport master (
    output req,
    input  sel,
    input  grant,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output sel,
    output grant,
    output busy,
    output preempt
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority encoder. It finds the first set request strictly after ptr, modulo 8.
// This block is purely combinational.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [SEL_W:0]     shamt_s;
  logic [N_REQ-1:0]   rot_s;
  logic [SEL_W-1:0]   off_s;

  // Rotate right by ptr+1, so that bit 0 of rot_s is the highest-priority source.
  always_comb begin
    dbl_s   = {req, req};
    shamt_s = {1'b0, ptr} + 4'd1;
    rot_s   = dbl_s[shamt_s +: N_REQ];
  end

  // Find the lowest set bit of the rotated vector, then map it back to an absolute index.
  always_comb begin
    off_s = {SEL_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? SEL_W'(i) : off_s;
    end
    any = |rot_s;
    idx = ptr + 3'd1 + off_s;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that drives the select input of an 8:1 single-bit mux.
// When MUX_ARB_TIMEOUT_EN is defined, a grant ends after HOLD_MAX cycles and
// preempt pulses for one cycle. In the default build, a grant lasts until the owner releases it.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_arbiter_if.slave    bus
);

  // Elaboration-time check that the hold limit fits the 8-bit counter.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux_rr_arbiter: HOLD_MAX must be in 1..255");
  end

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q,  busy_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  logic             pick_any_s;
  logic [SEL_W-1:0] pick_idx_s;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;
`endif

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Compute the next state and the next output values from the request vector and the current owner.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = BUSY;
          sel_d   = pick_idx_s;
          grant_d = idx_to_onehot(pick_idx_s);
          busy_d  = 1'b1;
          ptr_d   = pick_idx_s;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end else begin
          grant_d = {N_REQ{1'b0}};
          busy_d  = 1'b0;
        end
      end
      BUSY: begin
        if (!bus.req[sel_q]) begin
          // The owner has released. sel keeps its last value.
          state_d = IDLE;
          grant_d = {N_REQ{1'b0}};
          busy_d  = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        end else if (cnt_q == HOLD_LIM) begin
          // The hold limit is reached while the owner still requests. Take the grant back.
          // ptr already points at the owner, so the other requesters come first next time.
          state_d   = IDLE;
          grant_d   = {N_REQ{1'b0}};
          busy_d    = 1'b0;
          preempt_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
`else
        end else begin
          grant_d = grant_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {N_REQ{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register the state, the outputs and the round-robin pointer. rst loads the reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= {SEL_W{1'b0}};
      grant_q <= {N_REQ{1'b0}};
      busy_q  <= 1'b0;
      ptr_q   <= 3'd7;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= {CNT_W{1'b0}};
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
`endif
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
`ifdef MUX_ARB_TIMEOUT_EN
  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = 1'b0;
`endif

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 8:1 single-bit select mux among eight requesters. It samples a request vector, grants exactly one requester at a time, and drives the mux's 3-bit select with the granted index. It holds the grant until the owner releases, with an optional hold-time limit. It sits directly in front of the mux select input, and its grant vector is returned to the requesters.

## Interface
- `HOLD_MAX`, default 16: maximum grant length in cycles when the timeout feature is compiled in; legal range 1..255.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: request per source; bit i drives mux input i.
- `sel` output 3: mux select, equals the granted index while `busy`=1.
- `grant` output 8: one-hot grant; all zero when idle.
- `busy` output 1: a grant is active.
- `preempt` output 1: one-cycle pulse when a grant is forcibly ended by timeout.

## Operation
- All outputs are registered. Reset values: `sel`=0, `grant`=0, `busy`=0, `preempt`=0, state IDLE, `ptr`=7, `cnt`=0.
- `ptr` holds the last granted index. The search order is `ptr`+1, `ptr`+2, … modulo 8, so after reset index 0 has top priority.
- State IDLE:
  - If `req`≠0, grant the first set bit in search order.
  - Load `sel` with its index and `grant` with its one-hot code, set `busy`=1, set `ptr` to that index, set `cnt`=1, and go to BUSY.
  - If `req`=0, stay in IDLE with outputs zero.
- State BUSY:
  - If `req[sel]`=0, clear `grant` and `busy` and go to IDLE. `sel` keeps its last value.
  - Otherwise hold all outputs and increment `cnt` (8-bit, saturating).
  - Changes on non-granted `req` bits are ignored while in BUSY.
- Timeout (only when compiled in):
  - In BUSY, if `req[sel]`=1 and `cnt`==`HOLD_MAX`, clear `grant`/`busy`, pulse `preempt`=1 for one cycle, and go to IDLE.
  - `ptr` already points at the preempted source, so the next arbitration favours the others.
  - The preempted source is re-granted if it is the only requester.
- Simultaneous events:
  - If the owner drops `req` in the same cycle the timeout expires, it is treated as a normal release and `preempt` stays 0.
- Invariants: `grant` is always zero or one-hot, and `grant`==(1<<`sel`) whenever `busy`=1.

## Timing
- Arbitration latency: `req` sampled at edge t means `grant`/`sel` are valid after edge t+1 (one registered cycle).
- Release latency: the owner deasserts `req` before edge t, and `grant`=0 after edge t.
- Back-to-back: every ownership change includes exactly one cycle with `busy`=0.
- Timeout case: `grant` is high for exactly `HOLD_MAX` cycles, `preempt` is high in the first idle cycle, and the next grant appears one cycle later.
- Reset mid-grant: after the `rst` edge, all outputs reach reset values on the next cycle regardless of `req`. Arbitration resumes on the first edge with `rst`=0.
- Throughput: with continuous requests and no releases, timeout yields a rotation period of `HOLD_MAX`+1 cycles per source.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined: `cnt` comparison and `preempt` are active as described above.
- Not defined:
  - Grants last until the owner releases, with no limit.
  - `preempt` is tied to 0.
  - The `cnt` register is not built, and `HOLD_MAX` is unused.

## Structure
- Package `mux_arb_pkg`:
  - `N_REQ`=8 and `SEL_W`=3 constants.
  - State enum `arb_state_t` {IDLE, BUSY}.
  - `CNT_W`=8.
- Sub-module `rr_pick`: purely combinational rotating priority encoder.
  - Inputs: `req`[7:0], `ptr`[2:0].
  - Outputs: `any`, `idx`[2:0].
  - Implemented by rotating `req` right by `ptr`+1, finding the first set bit, then adding back modulo 8.
- The top level contains the FSM, output registers, `ptr` and, under the macro, `cnt`.

## Test plan
- Reset then `req`=8'b0000_0001 → after one cycle `grant`=8'h01, `sel`=0, `busy`=1. Drop `req` → `grant`=0 on the next cycle.
- `req`=8'hFF held, owners each drop for one cycle after a 3-cycle hold → grant order 0,1,2,…,7,0, with one idle cycle between grants.
- `ptr`=5 (last grant 5), `req`=8'b0010_0001 → grant goes to index 0 (`sel`=0), not 5.
- Timeout on, `HOLD_MAX`=4:
  - `req`=8'h09 held → `grant` 8'h01 for 4 cycles, `preempt` pulse, then `grant` 8'h08 for 4 cycles, `preempt`, then back to 8'h01.
- Timeout on, `HOLD_MAX`=4, owner drops `req` in cycle 4 → no `preempt`.
- Timeout on, `HOLD_MAX`=4, single requester 8'h04 held → re-granted after each preempt gap.
- Assert `rst` for one cycle during an active grant → `grant`=0, `busy`=0, `sel`=0 next cycle; with `req`=8'h80 held, the first post-reset grant is 8'h80.
